ej32_dstack: RTL and testbench

Parametrised data-stack engine for the eJ32 arithmetic unit. It owns the TOS register and the NOS array, and executes one stack opcode per enabled cycle. Beyond the plain push/pop/move set, it adds POP2, PICK and CLR, a depth counter, and sticky overflow/underflow flags. The AU drives it from its opcode dispatcher in place of its own inline stack; the control bus reads TOS/NOS back from t_o/s_o.

---
 rtl/ej32_dstack.sv | 141 ++++++++++++++
 tb/tb_ej32_dstack.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ej32_dstack.sv
// eJ32 data stack: TOS register plus an SS_DEPTH-entry NOS array.
// Executes one stack opcode per enabled cycle and tracks depth and sticky errors.
module ej32_dstack #(
  parameter  int DSZ      = 32,
  parameter  int SS_DEPTH = 32,
  localparam int ASZ      = $clog2(SS_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2:0]     op,
  input  logic           t_we,
  input  logic [DSZ-1:0] t_in,
  input  logic [ASZ-1:0] pick_n,
  input  logic           err_clr,
  output logic [DSZ-1:0] t_o,
  output logic [DSZ-1:0] s_o,
  output logic [ASZ:0]   depth_o,
  output logic           empty_o,
  output logic           full_o,
  output logic           ovf_o,
  output logic           unf_o
);

  localparam logic [2:0] S_NOP  = 3'd0;
  localparam logic [2:0] S_PUSH = 3'd1;
  localparam logic [2:0] S_POP  = 3'd2;
  localparam logic [2:0] S_MOVE = 3'd3;
  localparam logic [2:0] S_POP2 = 3'd4;
  localparam logic [2:0] S_PICK = 3'd5;
  localparam logic [2:0] S_CLR  = 3'd6;

  localparam logic [ASZ:0] DEPTH_MAX = (ASZ+1)'(SS_DEPTH);

  logic [DSZ-1:0] ss_q [SS_DEPTH];
  logic [DSZ-1:0] t_q, t_d;
  logic [ASZ-1:0] sp_q, sp_d;
  logic [ASZ:0]   depth_q, depth_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           ovf_set, unf_set;
  logic           wr_en;
  logic [ASZ-1:0] wr_addr;
  logic [ASZ-1:0] rd_addr;
  logic [DSZ-1:0] rd_data;
  logic           is_empty, is_full;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DEPTH_MAX);

  // Second read port serves both sPOP2 (ss[sp-1]) and sPICK (ss[sp-n]).
  assign rd_addr = (op == S_POP2) ? (sp_q - ASZ'(1)) : (sp_q - pick_n);
  assign rd_data = ss_q[rd_addr];

  always_comb begin
    t_d     = t_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    wr_en   = 1'b0;
    wr_addr = sp_q;
    if (en) begin
      case (op)
        S_PUSH: begin
          wr_en   = 1'b1;
          wr_addr = sp_q + ASZ'(1);
          sp_d    = sp_q + ASZ'(1);
          if (t_we) t_d = t_in;
          if (is_full) ovf_set = 1'b1;
          else         depth_d = depth_q + (ASZ+1)'(1);
        end
        S_POP: begin
          t_d  = t_we ? t_in : s_o;
          sp_d = sp_q - ASZ'(1);
          if (is_empty) unf_set = 1'b1;
          else          depth_d = depth_q - (ASZ+1)'(1);
        end
        S_POP2: begin
          t_d  = t_we ? t_in : rd_data;
          sp_d = sp_q - ASZ'(2);
          if (depth_q < (ASZ+1)'(2)) begin
            unf_set = 1'b1;
            depth_d = '0;
          end else begin
            depth_d = depth_q - (ASZ+1)'(2);
          end
        end
        S_MOVE: begin
          wr_en   = 1'b1;
          wr_addr = sp_q;
          t_d     = t_we ? t_in : s_o;
          if (is_empty) unf_set = 1'b1;
        end
        S_PICK: begin
          t_d = rd_data;
          if ({1'b0, pick_n} >= depth_q) unf_set = 1'b1;
        end
        S_CLR: begin
          sp_d    = '0;
          depth_d = '0;
        end
        default: begin
          if (t_we) t_d = t_in;
        end
      endcase
    end
    // A fresh error in the same cycle as err_clr leaves the flag set.
    ovf_d = (ovf_q & ~err_clr) | ovf_set;
    unf_d = (unf_q & ~err_clr) | unf_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q     <= '0;
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      t_q     <= t_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Single write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) ss_q[wr_addr] <= t_q;
  end

  assign t_o     = t_q;
  assign s_o     = ss_q[sp_q];
  assign depth_o = depth_q;
  assign empty_o = is_empty;
  assign full_o  = is_full;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: tb/tb_ej32_dstack.sv
// Directed bench for ej32_dstack with SS_DEPTH=4, DSZ=32.
module tb_ej32_dstack;
  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, MOVE = 3'd3,
                         POP2 = 3'd4, PICK = 3'd5, CLR = 3'd6, RSV = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        t_we = 1'b0;
  logic [31:0] t_in = 32'd0;
  logic [1:0]  pick_n = 2'd0;
  logic        err_clr = 1'b0;
  logic [31:0] t_o, s_o;
  logic [2:0]  depth_o;
  logic        empty_o, full_o, ovf_o, unf_o;

  int total = 0;
  int bad = 0;

  ej32_dstack #(.DSZ(32), .SS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .t_we(t_we), .t_in(t_in),
    .pick_n(pick_n), .err_clr(err_clr), .t_o(t_o), .s_o(s_o),
    .depth_o(depth_o), .empty_o(empty_o), .full_o(full_o),
    .ovf_o(ovf_o), .unf_o(unf_o)
  );

  always #5 clk = ~clk;

  // One enabled (or not) clock edge; outputs sampled 1 time unit after it.
  task automatic step(input logic [2:0] o, input logic we, input logic [31:0] d,
                      input logic [1:0] pn, input logic ec, input logic e);
    op = o; t_we = we; t_in = d; pick_n = pn; err_clr = ec; en = e;
    @(posedge clk); #1;
    en = 1'b0; t_we = 1'b0; err_clr = 1'b0; op = NOP;
    $display("op=%0d en=%0d we=%0d tin=%0d -> t=%0d s=%0h depth=%0d ovf=%0d unf=%0d",
             o, e, we, d, t_o, s_o, depth_o, ovf_o, unf_o);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; #2; rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1; rst = 1'b0;
    total++; if (t_o !== 32'd0) begin bad++; $display("FAIL reset_t got=%0d want=0", t_o); end
    total++; if (depth_o !== 3'd0) begin bad++; $display("FAIL reset_depth got=%0d want=0", depth_o); end
    total++; if ({empty_o, full_o, ovf_o, unf_o} !== 4'b1000) begin bad++;
      $display("FAIL reset_flags got=%b want=1000", {empty_o, full_o, ovf_o, unf_o}); end
  endtask

  task automatic test_push_pop();
    pulse_reset();
    step(PUSH, 1, 32'd1, 0, 0, 1);
    step(PUSH, 1, 32'd2, 0, 0, 1);
    step(PUSH, 1, 32'd3, 0, 0, 1);
    total++; if (t_o !== 32'd3) begin bad++; $display("FAIL push_t got=%0d want=3", t_o); end
    total++; if (s_o !== 32'd2) begin bad++; $display("FAIL push_s got=%0d want=2", s_o); end
    total++; if (depth_o !== 3'd3) begin bad++; $display("FAIL push_depth got=%0d want=3", depth_o); end
    step(POP, 0, 32'd0, 0, 0, 1);
    step(POP, 0, 32'd0, 0, 0, 1);
    total++; if (t_o !== 32'd1) begin bad++; $display("FAIL pop_t got=%0d want=1", t_o); end
    total++; if (depth_o !== 3'd1) begin bad++; $display("FAIL pop_depth got=%0d want=1", depth_o); end
    total++; if ({ovf_o, unf_o} !== 2'b00) begin bad++; $display("FAIL pop_flags got=%b want=00", {ovf_o, unf_o}); end
  endtask

  task automatic test_move();
    pulse_reset();
    step(PUSH, 1, 32'd9, 0, 0, 1);
    step(PUSH, 1, 32'd5, 0, 0, 1);
    step(MOVE, 0, 32'd0, 0, 0, 1);
    total++; if ({t_o, s_o} !== {32'd9, 32'd5}) begin bad++;
      $display("FAIL move1 got t=%0d s=%0d want t=9 s=5", t_o, s_o); end
    step(MOVE, 0, 32'd0, 0, 0, 1);
    total++; if ({t_o, s_o} !== {32'd5, 32'd9}) begin bad++;
      $display("FAIL move2 got t=%0d s=%0d want t=5 s=9", t_o, s_o); end
    total++; if (depth_o !== 3'd2) begin bad++; $display("FAIL move_depth got=%0d want=2", depth_o); end
  endtask

  task automatic test_overflow();
    pulse_reset();
    for (int i = 1; i <= 5; i++) step(PUSH, 1, 32'(i * 10), 0, 0, 1);
    step(PUSH, 1, 32'd60, 0, 0, 1);
    total++; if (depth_o !== 3'd4) begin bad++; $display("FAIL ovf_depth got=%0d want=4", depth_o); end
    total++; if ({full_o, ovf_o} !== 2'b11) begin bad++; $display("FAIL ovf_flags got=%b want=11", {full_o, ovf_o}); end
    step(POP, 0, 32'd0, 0, 0, 1);
    total++; if (t_o !== 32'd50) begin bad++; $display("FAIL ovf_pop_t got=%0d want=50", t_o); end
    total++; if ({full_o, ovf_o, depth_o} !== {2'b01, 3'd3}) begin bad++;
      $display("FAIL ovf_sticky got full=%b ovf=%b depth=%0d want 0 1 3", full_o, ovf_o, depth_o); end
    step(NOP, 0, 32'd0, 0, 1, 0);
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", ovf_o); end
  endtask

  task automatic test_pick();
    pulse_reset();
    step(NOP, 1, 32'd11, 0, 0, 1);
    step(PUSH, 1, 32'd22, 0, 0, 1);
    step(PUSH, 1, 32'd33, 0, 0, 1);
    step(PUSH, 1, 32'd44, 0, 0, 1);
    step(PICK, 1, 32'd99, 2'd0, 0, 1);
    total++; if (t_o !== 32'd33) begin bad++; $display("FAIL pick0 got=%0d want=33", t_o); end
    step(PICK, 0, 32'd0, 2'd2, 0, 1);
    total++; if ({t_o, depth_o} !== {32'd11, 3'd3}) begin bad++;
      $display("FAIL pick2 got t=%0d depth=%0d want t=11 depth=3", t_o, depth_o); end
    total++; if (unf_o !== 1'b0) begin bad++; $display("FAIL pick2_unf got=%b want=0", unf_o); end
    step(PICK, 0, 32'd0, 2'd3, 0, 1);
    total++; if ({unf_o, depth_o} !== {1'b1, 3'd3}) begin bad++;
      $display("FAIL pick3 got unf=%b depth=%0d want unf=1 depth=3", unf_o, depth_o); end
  endtask

  task automatic test_pop2_errclr();
    pulse_reset();
    step(PUSH, 1, 32'd7, 0, 0, 1);
    step(POP2, 1, 32'd99, 0, 1, 1);
    total++; if ({depth_o, empty_o, unf_o} !== {3'd0, 1'b1, 1'b1}) begin bad++;
      $display("FAIL pop2 got depth=%0d empty=%b unf=%b want 0 1 1", depth_o, empty_o, unf_o); end
    total++; if (t_o !== 32'd99) begin bad++; $display("FAIL pop2_t got=%0d want=99", t_o); end
    step(NOP, 0, 32'd0, 0, 1, 0);
    total++; if (unf_o !== 1'b0) begin bad++; $display("FAIL pop2_clr got=%b want=0", unf_o); end
    // Normal sPOP2 with enough depth takes ss[sp-1].
    step(PUSH, 1, 32'd1, 0, 0, 1);
    step(PUSH, 1, 32'd2, 0, 0, 1);
    step(PUSH, 1, 32'd3, 0, 0, 1);
    step(POP2, 0, 32'd0, 0, 0, 1);
    total++; if ({t_o, depth_o, unf_o} !== {32'd1, 3'd1, 1'b0}) begin bad++;
      $display("FAIL pop2_ok got t=%0d depth=%0d unf=%b want 1 1 0", t_o, depth_o, unf_o); end
  endtask

  task automatic test_clr_rsv_unf();
    pulse_reset();
    step(PUSH, 1, 32'd1, 0, 0, 1);
    step(PUSH, 1, 32'd2, 0, 0, 1);
    step(CLR, 0, 32'd0, 0, 0, 1);
    total++; if ({t_o, depth_o, empty_o} !== {32'd2, 3'd0, 1'b1}) begin bad++;
      $display("FAIL clr got t=%0d depth=%0d empty=%b want 2 0 1", t_o, depth_o, empty_o); end
    step(RSV, 1, 32'd42, 0, 0, 1);
    total++; if ({t_o, depth_o} !== {32'd42, 3'd0}) begin bad++;
      $display("FAIL rsv got t=%0d depth=%0d want 42 0", t_o, depth_o); end
    step(POP, 1, 32'd8, 0, 0, 1);
    total++; if ({unf_o, depth_o, t_o} !== {1'b1, 3'd0, 32'd8}) begin bad++;
      $display("FAIL pop_empty got unf=%b depth=%0d t=%0d want 1 0 8", unf_o, depth_o, t_o); end
  endtask

  task automatic test_async_reset_en();
    pulse_reset();
    for (int i = 1; i <= 5; i++) step(PUSH, 1, 32'(i), 0, 0, 1);
    total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL burst_ovf got=%b want=1", ovf_o); end
    op = PUSH; t_we = 1'b1; t_in = 32'd77; en = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++; if ({t_o, depth_o, ovf_o, unf_o} !== {32'd0, 3'd0, 2'b00}) begin bad++;
      $display("FAIL async_rst got t=%0d depth=%0d ovf=%b unf=%b want 0 0 0 0", t_o, depth_o, ovf_o, unf_o); end
    en = 1'b0;
    #1 rst = 1'b0;
    step(PUSH, 1, 32'd55, 0, 0, 0);
    total++; if ({t_o, depth_o} !== {32'd0, 3'd0}) begin bad++;
      $display("FAIL en_low got t=%0d depth=%0d want 0 0", t_o, depth_o); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_move();
    test_overflow();
    test_pick();
    test_pop2_errclr();
    test_clr_rsv_unf();
    test_async_reset_en();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
